bcd_field_reg: RTL and testbench
================================

Name: bcd_field_reg

Overview:
Parametrised BCD storage register for one real-time-clock calendar/time field: seconds, minutes, hours, day or month. Supports validated parallel load, increment and decrement with wrap-around between configurable bounds, and a run-time maximum for days-per-month. Registered carry/borrow pulses cascade into the next-higher field; the value output drives the display/VGA formatting path.

Parameters:
DIGITS, 2, number of BCD digits; value width is 4*DIGITS
MIN_VAL, 1, lowest legal decimal value (0 for sec/min/hour, 1 for day/month)
MAX_VAL, 31, highest legal decimal value; must be <= 10^DIGITS-1
RESET_VAL, 1, decimal value loaded on reset; MIN_VAL <= RESET_VAL <= MAX_VAL

Ports:
clk  in  1  system clock; all state changes on rising edge
reset  in  1  synchronous, active-high reset
load_en  in  1  load request for load_data
load_data  in  4*DIGITS  BCD value to load
inc  in  1  increment request
dec  in  1  decrement request
max_sel  in  1  1 = use dyn_max as upper bound, 0 = use MAX_VAL
dyn_max  in  4*DIGITS  BCD run-time maximum (days in current month)
value  out  4*DIGITS  current BCD field value, registered
carry  out  1  one-cycle pulse on upward wrap
borrow  out  1  one-cycle pulse on downward wrap
load_err  out  1  one-cycle pulse on rejected load

Behaviour:
- Reset (synchronous, active-high): value = RESET_VAL in BCD; carry = borrow = load_err = 0. Reset overrides every other input in the same cycle.
- Priority after reset: load_en > inc/dec. A cycle with load_en ignores inc and dec.
- Latency: one clock. The updated value and any carry/borrow/load_err pulse appear together on the edge after the request. All pulse outputs are 0 in any cycle with no event.
- Effective maximum (eff_max):
  - Equals dyn_max when max_sel=1 and dyn_max is valid BCD with MIN_VAL <= dyn_max <= MAX_VAL.
  - Otherwise equals MAX_VAL. An invalid dyn_max falls back silently.
- Load:
  - Accepted only if every nibble <= 9 and MIN_VAL <= decimal(load_data) <= eff_max. Accepted load sets value = load_data.
  - Rejected load holds value and pulses load_err.
- inc only:
  - If value >= eff_max: value = MIN_VAL and carry pulses.
  - Else value + 1 with BCD digit carry (e.g. 09 -> 10, 19 -> 20).
- dec only:
  - If value > eff_max: value = eff_max, no borrow. This is the clamp case after eff_max drops.
  - If value <= MIN_VAL: value = eff_max and borrow pulses.
  - Else value - 1 with BCD digit borrow (e.g. 10 -> 09).
- inc and dec together: value held, no pulses.
- eff_max lowered below the current value (e.g. day 31, month changes to 30): value is held until the next request. No spontaneous change.
- Back-to-back requests on consecutive cycles are each honoured, one step per cycle. A continuously held inc counts every cycle.
- value never holds a non-BCD nibble. Implementation may count in binary internally but must present BCD.

Test Plan:
All scenarios use DIGITS=2, MIN_VAL=1, MAX_VAL=31, RESET_VAL=1.
1. Reset: assert reset together with load_en=1, load_data=8'h15 -> next edge value=8'h01, carry=borrow=load_err=0.
2. Increment wrap: load 8'h28, then inc for 4 cycles -> value 29, 30, 31, 01 (BCD); carry=1 only in the cycle value becomes 01. Separately, from 8'h09, inc -> 8'h10.
3. Decrement wrap: from 8'h01, dec -> 8'h31 with borrow=1. From 8'h10, dec -> 8'h09 with no borrow.
4. Rejected loads: load 8'h3A, 8'h32 and 8'h00 -> each pulses load_err for one cycle; value unchanged. Load 8'h31 -> accepted, no load_err.
5. Dynamic max:
   - max_sel=1, dyn_max=8'h28, value 8'h28, inc -> 8'h01 with carry.
   - value 8'h31, dyn_max=8'h30: hold -> stays 8'h31; inc -> 8'h01 with carry; dec from 8'h31 -> 8'h30 with no borrow.
   - dyn_max=8'h45 (out of range) -> acts as 31.
6. Simultaneous and mid-operation events:
   - inc=dec=1 -> value held, no pulses.
   - Reset asserted during a run of incs at 8'h17 -> value 8'h01 next edge; counting resumes from 01 after reset drops.

Source files
------------

// File: rtl/bcd_field_reg.sv
// BCD register for one RTC calendar/time field with validated load, wrapping
// inc/dec between MIN_VAL and a static or run-time maximum, and carry/borrow pulses.
module bcd_field_reg #(
  parameter int DIGITS    = 2,
  parameter int MIN_VAL   = 1,
  parameter int MAX_VAL   = 31,
  parameter int RESET_VAL = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic [4*DIGITS-1:0]   load_data,
  input  logic                  inc,
  input  logic                  dec,
  input  logic                  max_sel,
  input  logic [4*DIGITS-1:0]   dyn_max,
  output logic [4*DIGITS-1:0]   value,
  output logic                  carry,
  output logic                  borrow,
  output logic                  load_err
);

  localparam int W = 4*DIGITS;
  // 16^DIGITS > 10^DIGITS, so a W-bit binary holds any legal field value.
  localparam logic [W-1:0] MIN_B = MIN_VAL[W-1:0];
  localparam logic [W-1:0] MAX_B = MAX_VAL[W-1:0];
  localparam logic [W-1:0] RST_B = RESET_VAL[W-1:0];

  function automatic logic [W-1:0] to_bin(input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    for (int i = DIGITS-1; i >= 0; i--) r = r * W'(10) + W'(b[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input logic [W-1:0] x);
    logic [W-1:0] r;
    logic [W-1:0] v;
    r = '0;
    v = x;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % W'(10));
      v = v / W'(10);
    end
    return r;
  endfunction

  function automatic logic is_bcd(input logic [W-1:0] b);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) if (b[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  logic [W-1:0] val_bin, dyn_bin, ld_bin, eff_max;
  logic         dyn_ok, ld_ok;
  logic [W-1:0] value_nxt;
  logic         carry_nxt, borrow_nxt, load_err_nxt;

  assign val_bin = to_bin(value);
  assign dyn_bin = to_bin(dyn_max);
  assign ld_bin  = to_bin(load_data);

  // An out-of-range or non-BCD dyn_max silently falls back to MAX_VAL.
  assign dyn_ok  = is_bcd(dyn_max) && (dyn_bin >= MIN_B) && (dyn_bin <= MAX_B);
  assign eff_max = (max_sel && dyn_ok) ? dyn_bin : MAX_B;
  assign ld_ok   = is_bcd(load_data) && (ld_bin >= MIN_B) && (ld_bin <= eff_max);

  always_comb begin
    value_nxt    = value;
    carry_nxt    = 1'b0;
    borrow_nxt   = 1'b0;
    load_err_nxt = 1'b0;
    if (load_en) begin
      if (ld_ok) value_nxt = load_data;
      else       load_err_nxt = 1'b1;
    end else if (inc && !dec) begin
      if (val_bin >= eff_max) begin
        value_nxt = to_bcd(MIN_B);
        carry_nxt = 1'b1;
      end else begin
        value_nxt = to_bcd(val_bin + W'(1));
      end
    end else if (dec && !inc) begin
      // Value stranded above a lowered maximum clamps down without a borrow.
      if (val_bin > eff_max) begin
        value_nxt = to_bcd(eff_max);
      end else if (val_bin <= MIN_B) begin
        value_nxt  = to_bcd(eff_max);
        borrow_nxt = 1'b1;
      end else begin
        value_nxt = to_bcd(val_bin - W'(1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value    <= to_bcd(RST_B);
      carry    <= 1'b0;
      borrow   <= 1'b0;
      load_err <= 1'b0;
    end else begin
      value    <= value_nxt;
      carry    <= carry_nxt;
      borrow   <= borrow_nxt;
      load_err <= load_err_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_field_reg.sv
// Directed bench for bcd_field_reg (DIGITS=2, MIN 1, MAX 31, reset 1).
module tb_bcd_field_reg;

  logic       clk = 1'b0;
  logic       reset, load_en, inc, dec, max_sel;
  logic [7:0] load_data, dyn_max;
  logic [7:0] value;
  logic       carry, borrow, load_err;
  int         tests = 0;
  int         failed = 0;

  always #5 clk = ~clk;

  bcd_field_reg #(.DIGITS(2), .MIN_VAL(1), .MAX_VAL(31), .RESET_VAL(1)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_data(load_data),
    .inc(inc), .dec(dec), .max_sel(max_sel), .dyn_max(dyn_max),
    .value(value), .carry(carry), .borrow(borrow), .load_err(load_err)
  );

  // One cycle of stimulus plus its expected result; ef = {carry, borrow, load_err}.
  typedef struct {
    logic       rs, ld;
    logic [7:0] d;
    logic       i, de, ms;
    logic [7:0] dm, ev;
    logic [2:0] ef;
  } vec_t;

  function automatic vec_t v(logic rs, logic ld, logic [7:0] d, logic i, logic de,
                             logic ms, logic [7:0] dm, logic [7:0] ev, logic [2:0] ef);
    vec_t t;
    t.rs = rs; t.ld = ld; t.d = d; t.i = i; t.de = de;
    t.ms = ms; t.dm = dm; t.ev = ev; t.ef = ef;
    return t;
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic apply(input vec_t t);
    reset = t.rs; load_en = t.ld; load_data = t.d; inc = t.i; dec = t.de;
    max_sel = t.ms; dyn_max = t.dm;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    vec_t q[$];
    q.push_back(v(1, 1, 8'h15, 0, 0, 0, 8'h00, 8'h01, 3'b000));
    q.push_back(v(0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h01, 3'b000));
    foreach (q[k]) begin
      apply(q[k]);
      tests++;
      if ({value, carry, borrow, load_err} !== {q[k].ev, q[k].ef}) begin
        failed++;
        $display("FAIL reset[%0d]: value=%h cbl=%b, expected value=%h cbl=%b",
                 k, value, {carry, borrow, load_err}, q[k].ev, q[k].ef);
      end
    end
  endtask

  task automatic test_inc_wrap();
    vec_t q[$];
    q.push_back(v(0, 1, 8'h28, 0, 0, 0, 8'h00, 8'h28, 3'b000));
    q.push_back(v(0, 0, 8'h00, 1, 0, 0, 8'h00, 8'h29, 3'b000));
    q.push_back(v(0, 0, 8'h00, 1, 0, 0, 8'h00, 8'h30, 3'b000));
    q.push_back(v(0, 0, 8'h00, 1, 0, 0, 8'h00, 8'h31, 3'b000));
    q.push_back(v(0, 0, 8'h00, 1, 0, 0, 8'h00, 8'h01, 3'b100));
    q.push_back(v(0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h01, 3'b000));
    q.push_back(v(0, 1, 8'h09, 0, 0, 0, 8'h00, 8'h09, 3'b000));
    q.push_back(v(0, 0, 8'h00, 1, 0, 0, 8'h00, 8'h10, 3'b000));
    q.push_back(v(0, 1, 8'h19, 0, 0, 0, 8'h00, 8'h19, 3'b000));
    q.push_back(v(0, 0, 8'h00, 1, 0, 0, 8'h00, 8'h20, 3'b000));
    foreach (q[k]) begin
      apply(q[k]);
      tests++;
      if ({value, carry, borrow, load_err} !== {q[k].ev, q[k].ef}) begin
        failed++;
        $display("FAIL inc_wrap[%0d]: value=%h cbl=%b, expected value=%h cbl=%b",
                 k, value, {carry, borrow, load_err}, q[k].ev, q[k].ef);
      end
    end
  endtask

  task automatic test_dec_wrap();
    vec_t q[$];
    q.push_back(v(0, 1, 8'h01, 0, 0, 0, 8'h00, 8'h01, 3'b000));
    q.push_back(v(0, 0, 8'h00, 0, 1, 0, 8'h00, 8'h31, 3'b010));
    q.push_back(v(0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h31, 3'b000));
    q.push_back(v(0, 1, 8'h10, 0, 0, 0, 8'h00, 8'h10, 3'b000));
    q.push_back(v(0, 0, 8'h00, 0, 1, 0, 8'h00, 8'h09, 3'b000));
    foreach (q[k]) begin
      apply(q[k]);
      tests++;
      if ({value, carry, borrow, load_err} !== {q[k].ev, q[k].ef}) begin
        failed++;
        $display("FAIL dec_wrap[%0d]: value=%h cbl=%b, expected value=%h cbl=%b",
                 k, value, {carry, borrow, load_err}, q[k].ev, q[k].ef);
      end
    end
  endtask

  task automatic test_load_reject();
    vec_t q[$];
    q.push_back(v(0, 1, 8'h3A, 0, 0, 0, 8'h00, 8'h09, 3'b001));
    q.push_back(v(0, 1, 8'h32, 0, 0, 0, 8'h00, 8'h09, 3'b001));
    q.push_back(v(0, 1, 8'h00, 0, 0, 0, 8'h00, 8'h09, 3'b001));
    q.push_back(v(0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h09, 3'b000));
    q.push_back(v(0, 1, 8'h31, 0, 0, 0, 8'h00, 8'h31, 3'b000));
    q.push_back(v(0, 1, 8'h1F, 0, 0, 0, 8'h00, 8'h31, 3'b001));
    foreach (q[k]) begin
      apply(q[k]);
      tests++;
      if ({value, carry, borrow, load_err} !== {q[k].ev, q[k].ef}) begin
        failed++;
        $display("FAIL load_reject[%0d]: value=%h cbl=%b, expected value=%h cbl=%b",
                 k, value, {carry, borrow, load_err}, q[k].ev, q[k].ef);
      end
    end
  endtask

  task automatic test_dyn_max();
    vec_t q[$];
    q.push_back(v(0, 1, 8'h28, 0, 0, 1, 8'h28, 8'h28, 3'b000));
    q.push_back(v(0, 0, 8'h00, 1, 0, 1, 8'h28, 8'h01, 3'b100));
    q.push_back(v(0, 1, 8'h31, 0, 0, 0, 8'h30, 8'h31, 3'b000));
    q.push_back(v(0, 0, 8'h00, 0, 0, 1, 8'h30, 8'h31, 3'b000));
    q.push_back(v(0, 0, 8'h00, 1, 0, 1, 8'h30, 8'h01, 3'b100));
    q.push_back(v(0, 1, 8'h31, 0, 0, 0, 8'h30, 8'h31, 3'b000));
    q.push_back(v(0, 0, 8'h00, 0, 1, 1, 8'h30, 8'h30, 3'b000));
    q.push_back(v(0, 0, 8'h00, 0, 1, 1, 8'h30, 8'h29, 3'b000));
    q.push_back(v(0, 1, 8'h31, 0, 0, 1, 8'h30, 8'h29, 3'b001));
    q.push_back(v(0, 1, 8'h31, 0, 0, 1, 8'h45, 8'h31, 3'b000));
    q.push_back(v(0, 0, 8'h00, 1, 0, 1, 8'h45, 8'h01, 3'b100));
    q.push_back(v(0, 0, 8'h00, 0, 1, 1, 8'h45, 8'h31, 3'b010));
    q.push_back(v(0, 0, 8'h00, 1, 0, 1, 8'h2A, 8'h01, 3'b100));
    foreach (q[k]) begin
      apply(q[k]);
      tests++;
      if ({value, carry, borrow, load_err} !== {q[k].ev, q[k].ef}) begin
        failed++;
        $display("FAIL dyn_max[%0d]: value=%h cbl=%b, expected value=%h cbl=%b",
                 k, value, {carry, borrow, load_err}, q[k].ev, q[k].ef);
      end
    end
  endtask

  task automatic test_simultaneous();
    vec_t q[$];
    q.push_back(v(0, 1, 8'h15, 0, 0, 0, 8'h00, 8'h15, 3'b000));
    q.push_back(v(0, 0, 8'h00, 1, 1, 0, 8'h00, 8'h15, 3'b000));
    q.push_back(v(0, 1, 8'h20, 1, 0, 0, 8'h00, 8'h20, 3'b000));
    q.push_back(v(0, 1, 8'h3A, 0, 1, 0, 8'h00, 8'h20, 3'b001));
    foreach (q[k]) begin
      apply(q[k]);
      tests++;
      if ({value, carry, borrow, load_err} !== {q[k].ev, q[k].ef}) begin
        failed++;
        $display("FAIL simultaneous[%0d]: value=%h cbl=%b, expected value=%h cbl=%b",
                 k, value, {carry, borrow, load_err}, q[k].ev, q[k].ef);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t q[$];
    q.push_back(v(0, 1, 8'h15, 0, 0, 0, 8'h00, 8'h15, 3'b000));
    q.push_back(v(0, 0, 8'h00, 1, 0, 0, 8'h00, 8'h16, 3'b000));
    q.push_back(v(0, 0, 8'h00, 1, 0, 0, 8'h00, 8'h17, 3'b000));
    q.push_back(v(1, 0, 8'h00, 1, 0, 0, 8'h00, 8'h01, 3'b000));
    q.push_back(v(0, 0, 8'h00, 1, 0, 0, 8'h00, 8'h02, 3'b000));
    q.push_back(v(0, 0, 8'h00, 1, 0, 0, 8'h00, 8'h03, 3'b000));
    q.push_back(v(0, 0, 8'h00, 0, 1, 0, 8'h00, 8'h02, 3'b000));
    q.push_back(v(0, 0, 8'h00, 0, 1, 0, 8'h00, 8'h01, 3'b000));
    q.push_back(v(0, 0, 8'h00, 0, 1, 0, 8'h00, 8'h31, 3'b010));
    q.push_back(v(1, 0, 8'h00, 0, 1, 0, 8'h00, 8'h01, 3'b000));
    foreach (q[k]) begin
      apply(q[k]);
      tests++;
      if ({value, carry, borrow, load_err} !== {q[k].ev, q[k].ef}) begin
        failed++;
        $display("FAIL back_to_back[%0d]: value=%h cbl=%b, expected value=%h cbl=%b",
                 k, value, {carry, borrow, load_err}, q[k].ev, q[k].ef);
      end
    end
  endtask

  initial begin
    reset = 1'b1; load_en = 1'b0; load_data = 8'h00; inc = 1'b0; dec = 1'b0;
    max_sel = 1'b0; dyn_max = 8'h00;
    #2;
    test_reset();
    test_inc_wrap();
    test_dec_wrap();
    test_load_reject();
    test_dyn_max();
    test_simultaneous();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
